parking_lot_controller: RTL
===========================

// Module: parking_lot_controller
// PURPOSE
//  Parametrised parking-lot manager. Allocates the lowest-numbered free space on entry,
//  releases a space by number on exit, and tracks occupancy, free count and full/empty.
//  Runs a timed entry-gate FSM. Sits between the gate sensors/keypad and the display logic.
// PARAMETERS
//  N_SPACES     8   number of parking spaces (2..64)
//  IDX_W        3   space-index width, $clog2(N_SPACES)
//  CNT_W        4   free-count width, $clog2(N_SPACES+1)
//  GATE_CYCLES  4   cycles gate_open is held high after a grant (>=1)
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-high
//  entry_req    in   1        level; car at entry; held until entry_grant/entry_reject
//  exit_req     in   1        one-cycle pulse; car leaving space exit_slot
//  exit_slot    in   IDX_W    space number being vacated (sampled with exit_req)
//  entry_grant  out  1        one-cycle pulse: space allocated
//  entry_slot   out  IDX_W    allocated space number; valid with entry_grant, held after
//  entry_reject out  1        one-cycle pulse: lot full
//  exit_ack     out  1        one-cycle pulse: space released
//  exit_error   out  1        one-cycle pulse: exit_slot out of range or already free
//  gate_open    out  1        entry gate drive
//  occupancy    out  N_SPACES one-hot-per-space map; bit i=1 means space i taken
//  free_count   out  CNT_W    number of free spaces
//  full         out  1        free_count==0
//  empty        out  1        free_count==N_SPACES
// BEHAVIOUR
//  - All outputs registered. Reset (async, any state): occupancy=0, free_count=N_SPACES,
//    empty=1, full=0, all pulses=0, entry_slot=0, gate_open=0, FSM->IDLE, gate timer=0.
//  - Gate FSM: IDLE, OPEN.
//    IDLE & entry_req & !full: the lowest i with occupancy[i]==0 (pre-edge map) is selected;
//      next cycle: occupancy[i]=1, entry_slot=i, entry_grant=1, gate_open=1, FSM->OPEN.
//    IDLE & entry_req & full: next cycle entry_reject=1; no state change; stays IDLE.
//    OPEN: gate_open high exactly GATE_CYCLES cycles, counted from the grant cycle, then
//      ->IDLE. entry_req is ignored in OPEN (no grant, no reject). The requester holds
//      entry_req until a response.
//  - Latency: request cycle N -> response pulse in cycle N+1.
//  - Exit is independent of the FSM and is accepted in any state:
//    exit_req & exit_slot<N_SPACES & occupancy[exit_slot]: next cycle bit cleared, exit_ack=1.
//    Otherwise: next cycle exit_error=1; no state change.
//  - Simultaneous entry grant + exit in the same cycle: both take effect.
//    Allocation and validity both use the pre-edge map. A space freed this cycle is
//    not reused this cycle.
//    full & exit same cycle: entry is rejected and the exit is acked.
//    Exit naming the space being allocated this cycle raises exit_error.
//  - free_count = N_SPACES - popcount(occupancy). It is updated by +1 (exit), -1 (grant),
//    or 0 (both or neither). It never wraps. full and empty are derived registered flags
//    and are consistent with free_count in the same cycle.
//  - Reset mid-OPEN closes the gate immediately and clears all occupancy.
// STRUCTURE
//  - Shared header parking_defs.vh: FSM state encodings (ST_IDLE=1'b0, ST_OPEN=1'b1) and
//    default N_SPACES/GATE_CYCLES constants.
//  - Sub-module park_slot_allocator (combinational). Inputs: occupancy.
//    Outputs: lowest-free index and an any_free flag (parametrised priority encoder).
//  - Exit release uses the exit_slot -> N_SPACES-bit one-hot decode, ANDed with the
//    range check.
// TESTING (N_SPACES=8, GATE_CYCLES=4)
//  1. Reset, then hold entry_req -> grant slot 0 at cycle+1, gate_open 4 cycles;
//     next grant slot 1 after gate closes. free_count 8->7->6.
//  2. Fill all 8 -> full=1, free_count=0; entry_req -> entry_reject pulse, occupancy=8'hFF.
//  3. occupancy=8'hFF; exit_req slot 3 with entry_req in the same cycle -> exit_ack,
//     entry_reject; next entry -> slot 3.
//  4. exit_req slot 5 with occupancy[5]=0 -> exit_error, no change. Repeat with N_SPACES=6
//     and exit_slot=7 -> exit_error.
//  5. occupancy=8'b0000_0101; exit slot 0 + entry same cycle -> grant slot 1, ack slot 0;
//     result 8'b0000_0110; free_count unchanged at 6.
//  6. Assert reset during OPEN (gate timer=2) -> gate_open=0, occupancy=0, free_count=8,
//     empty=1 without waiting for a clock edge.

Source files
------------

// File: rtl/parking_lot_controller_pkg.sv
// Shared definitions for the parking-lot controller: gate FSM encoding and default sizing.
package parking_lot_controller_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StOpen = 1'b1
  } gate_state_e;

  localparam int DefNSpaces    = 8;
  localparam int DefGateCycles = 4;

endpackage

// File: rtl/park_slot_allocator.sv
// Combinational priority encoder: lowest-numbered free space and an any-free flag.
module park_slot_allocator #(
  parameter int N_SPACES = 8,
  parameter int IDX_W    = 3
) (
  input  logic [N_SPACES-1:0] occupancy,
  output logic [IDX_W-1:0]    free_idx,
  output logic                any_free
);

  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = N_SPACES - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_lot_controller.sv
// Parking-lot manager: lowest-free allocation on entry, release by number on exit,
// occupancy/free-count tracking and a timed entry gate.
module parking_lot_controller
  import parking_lot_controller_pkg::*;
#(
  parameter int N_SPACES    = DefNSpaces,
  parameter int IDX_W       = $clog2(N_SPACES),
  parameter int CNT_W       = $clog2(N_SPACES + 1),
  parameter int GATE_CYCLES = DefGateCycles
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                entry_req,
  input  logic                exit_req,
  input  logic [IDX_W-1:0]    exit_slot,
  output logic                entry_grant,
  output logic [IDX_W-1:0]    entry_slot,
  output logic                entry_reject,
  output logic                exit_ack,
  output logic                exit_error,
  output logic                gate_open,
  output logic [N_SPACES-1:0] occupancy,
  output logic [CNT_W-1:0]    free_count,
  output logic                full,
  output logic                empty
);

  localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  gate_state_e           state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [IDX_W-1:0]      free_idx;
  logic                  any_free;
  logic                  grant, reject, exit_hit, in_range;
  logic [N_SPACES-1:0]   exit_dec, occ_d;
  logic [CNT_W-1:0]      fc_d;
  logic [IDX_W-1:0]      slot_d;
  logic                  gate_d;

  park_slot_allocator #(
    .N_SPACES(N_SPACES),
    .IDX_W   (IDX_W)
  ) u_alloc (
    .occupancy(occupancy),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gate_d   = gate_open;
    slot_d   = entry_slot;
    grant    = (state_q == StIdle) && entry_req && any_free;
    reject   = (state_q == StIdle) && entry_req && !any_free;
    in_range = {1'b0, exit_slot} < (IDX_W + 1)'(N_SPACES);
    exit_dec = {{(N_SPACES - 1){1'b0}}, 1'b1} << exit_slot;
    // The space being allocated is free in the pre-edge map, so naming it on exit errors.
    exit_hit = exit_req && in_range && |(occupancy & exit_dec);
    occ_d    = occupancy;
    fc_d     = free_count;

    if (exit_hit) occ_d = occ_d & ~exit_dec;
    if (grant) begin
      occ_d[free_idx] = 1'b1;
      slot_d          = free_idx;
    end
    if (grant && !exit_hit) fc_d = free_count - CNT_W'(1);
    if (exit_hit && !grant) fc_d = free_count + CNT_W'(1);

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StOpen;
          gate_d  = 1'b1;
          timer_d = TMR_W'(GATE_CYCLES - 1);
        end
      end
      StOpen: begin
        if (timer_q == '0) begin
          state_d = StIdle;
          gate_d  = 1'b0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      occupancy    <= '0;
      free_count   <= CNT_W'(N_SPACES);
      full         <= 1'b0;
      empty        <= 1'b1;
      entry_grant  <= 1'b0;
      entry_reject <= 1'b0;
      entry_slot   <= '0;
      exit_ack     <= 1'b0;
      exit_error   <= 1'b0;
      gate_open    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      occupancy    <= occ_d;
      free_count   <= fc_d;
      full         <= (fc_d == '0);
      empty        <= (fc_d == CNT_W'(N_SPACES));
      entry_grant  <= grant;
      entry_reject <= reject;
      entry_slot   <= slot_d;
      exit_ack     <= exit_hit;
      exit_error   <= exit_req && !exit_hit;
      gate_open    <= gate_d;
    end
  end

endmodule
